// File: rtl/multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_if
// Bundle between the instruction register / datapath and the multicycle
// sequencer. The sequencer side (master) consumes the IR fields and memory
// handshakes and produces datapath strobes, status and performance counters.
// The datapath side (slave) sees the same signals with opposite directions.
//
//   opcode, func      IR fields, stable from DECODE until retire
//   im_ack, dm_ack    instruction / data memory handshakes
//   stall             freeze request
//   state             current sequencer state
//   read_im .. pc_sel datapath strobes and selects
//   retire            last-cycle pulse of every instruction
//   halted, fault     sticky status
//   cycle_cnt,
//   retire_cnt        performance counters
// ---------------------------------------------------------------------------
interface multicycle_sequencer_if #(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6,
    parameter int CNT_W  = 32
);
    logic [OP_W-1:0]   opcode;
    logic [FUNC_W-1:0] func;
    logic              im_ack;
    logic              dm_ack;
    logic              stall;

    logic [2:0]        state;
    logic              read_im;
    logic              load_opnd;
    logic [3:0]        alu_func;
    logic              mux_b_imm;
    logic              load_aluout;
    logic              enable_dm;
    logic              write_dm;
    logic              load_lmd;
    logic              write_reg;
    logic              mux_dst_rt;
    logic              mux_w_lmd;
    logic              load_pc;
    logic [2:0]        pc_sel;
    logic              retire;
    logic              halted;
    logic [1:0]        fault;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        input  opcode, func, im_ack, dm_ack, stall,
        output state, read_im, load_opnd, alu_func, mux_b_imm, load_aluout,
               enable_dm, write_dm, load_lmd, write_reg, mux_dst_rt, mux_w_lmd,
               load_pc, pc_sel, retire, halted, fault, cycle_cnt, retire_cnt
    );

    modport slave (
        output opcode, func, im_ack, dm_ack, stall,
        input  state, read_im, load_opnd, alu_func, mux_b_imm, load_aluout,
               enable_dm, write_dm, load_lmd, write_reg, mux_dst_rt, mux_w_lmd,
               load_pc, pc_sel, retire, halted, fault, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// FSM-based multicycle control unit for the RISC datapath. Decodes the IR
// opcode/func into an instruction class and walks FETCH/DECODE/EXEC/MEM/WB,
// issuing datapath strobes per state. Memory waits are bounded by a wait
// counter; a timeout, an illegal opcode or a halt instruction parks the
// sequencer in HALT until reset. Cycle and retire counters are kept.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous reset, active-low (0 = reset)
//   bus    master modport of multicycle_sequencer_if (IR fields, memory
//          acks, stall in; state, strobes, status, counters out)
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6,
    parameter int CNT_W  = 32,
    parameter int WAIT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] F_NONE    = 2'd0;
    localparam logic [1:0] F_ILLEGAL = 2'd1;
    localparam logic [1:0] F_IM_TO   = 2'd2;
    localparam logic [1:0] F_DM_TO   = 2'd3;

    // The wait counter holds the number of cycles already spent waiting, so
    // a value of 2**WAIT_W-2 means the current cycle is the last allowed one.
    localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    // Instruction class decode
    logic [1:0] cls;
    logic [2:0] sub_op;
    logic       is_reg, is_imm, is_mb, is_illegal;
    logic       is_ld, is_st, is_halt, is_ldst;
    logic       wait_at_limit;
    logic [2:0] branch_sel;

    assign cls        = bus.opcode[5:4];
    assign sub_op     = bus.opcode[2:0];
    assign is_reg     = (cls == 2'b00);
    assign is_illegal = (cls == 2'b01);
    assign is_mb      = (cls == 2'b10);
    assign is_imm     = (cls == 2'b11);
    assign is_ld      = is_mb && (sub_op == 3'd0);
    assign is_st      = is_mb && (sub_op == 3'd1);
    assign is_halt    = is_mb && (sub_op == 3'd7);
    assign is_ldst    = is_ld || is_st;
    assign wait_at_limit = (wait_q == WAIT_LAST);

    // func[FUNC_W-1:4] carries no meaning for this sequencer
    logic unused_func;
    assign unused_func = ^bus.func[FUNC_W-1:4];

    // Branch sub-ops 2..5 map onto PC sources 1..4; nop keeps NPC
    always_comb begin
        branch_sel = 3'd0;
        case (sub_op)
            3'd2:    branch_sel = 3'd1;
            3'd3:    branch_sel = 3'd2;
            3'd4:    branch_sel = 3'd3;
            3'd5:    branch_sel = 3'd4;
            default: branch_sel = 3'd0;
        endcase
    end

    // Output decode (Moore on state/class, qualified by the memory acks)
    logic       read_im_s, load_opnd_s, mux_b_imm_s, load_aluout_s;
    logic       enable_dm_s, write_dm_s, load_lmd_s, write_reg_s;
    logic       mux_dst_rt_s, mux_w_lmd_s, load_pc_s, retire_s;
    logic [3:0] alu_func_s;
    logic [2:0] pc_sel_s;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            fault_q      <= F_NONE;
            cycle_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            fault_q      <= fault_d;
            cycle_q      <= cycle_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        fault_d      = fault_q;
        cycle_d      = cycle_q;
        retire_cnt_d = retire_cnt_q;

        if (!bus.stall && state_q != S_HALT) begin
            cycle_d = cycle_q + CNT_ONE;

            case (state_q)
                S_FETCH: begin
                    // An ack in the limit cycle still completes the fetch
                    if (bus.im_ack) begin
                        state_d = S_DECODE;
                    end else if (wait_at_limit) begin
                        state_d = S_HALT;
                        fault_d = F_IM_TO;
                    end
                end
                S_DECODE: begin
                    if (is_illegal) begin
                        state_d = S_HALT;
                        fault_d = F_ILLEGAL;
                    end else if (is_halt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = (is_reg || is_imm) ? S_WB : S_MEM;
                end
                S_MEM: begin
                    if (is_ldst) begin
                        if (bus.dm_ack) begin
                            state_d = is_ld ? S_WB : S_FETCH;
                        end else if (wait_at_limit) begin
                            state_d = S_HALT;
                            fault_d = F_DM_TO;
                        end
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase

            // Only the two wait states can stay put; every move clears it
            wait_d = (state_d != state_q) ? '0 : wait_q + WAIT_ONE;

            if (retire_s) begin
                retire_cnt_d = retire_cnt_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        read_im_s     = 1'b0;
        load_opnd_s   = 1'b0;
        mux_b_imm_s   = 1'b0;
        load_aluout_s = 1'b0;
        enable_dm_s   = 1'b0;
        write_dm_s    = 1'b0;
        load_lmd_s    = 1'b0;
        write_reg_s   = 1'b0;
        mux_dst_rt_s  = 1'b0;
        mux_w_lmd_s   = 1'b0;
        load_pc_s     = 1'b0;
        retire_s      = 1'b0;
        alu_func_s    = 4'd0;
        pc_sel_s      = 3'd0;

        // Reset is folded in so strobes drop the moment reset is asserted,
        // not only after the state register has been cleared.
        if (reset && !bus.stall) begin
            case (state_q)
                S_FETCH: begin
                    read_im_s = 1'b1;
                end
                S_DECODE: begin
                    load_opnd_s = 1'b1;
                end
                S_EXEC: begin
                    load_aluout_s = 1'b1;
                    mux_b_imm_s   = is_imm || is_ldst;
                    if (is_reg) begin
                        alu_func_s = bus.func[3:0];
                    end else if (is_imm) begin
                        alu_func_s = bus.opcode[3:0];
                    end
                end
                S_MEM: begin
                    if (is_ldst) begin
                        enable_dm_s = 1'b1;
                        write_dm_s  = is_st;
                        if (bus.dm_ack) begin
                            load_lmd_s = is_ld;
                            load_pc_s  = is_st;
                            retire_s   = is_st;
                        end
                    end else begin
                        load_pc_s = 1'b1;
                        retire_s  = 1'b1;
                        pc_sel_s  = branch_sel;
                    end
                end
                S_WB: begin
                    write_reg_s  = 1'b1;
                    mux_dst_rt_s = is_imm || is_ld;
                    mux_w_lmd_s  = is_ld;
                    load_pc_s    = 1'b1;
                    retire_s     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.read_im     = read_im_s;
    assign bus.load_opnd   = load_opnd_s;
    assign bus.alu_func    = alu_func_s;
    assign bus.mux_b_imm   = mux_b_imm_s;
    assign bus.load_aluout = load_aluout_s;
    assign bus.enable_dm   = enable_dm_s;
    assign bus.write_dm    = write_dm_s;
    assign bus.load_lmd    = load_lmd_s;
    assign bus.write_reg   = write_reg_s;
    assign bus.mux_dst_rt  = mux_dst_rt_s;
    assign bus.mux_w_lmd   = mux_w_lmd_s;
    assign bus.load_pc     = load_pc_s;
    assign bus.pc_sel      = pc_sel_s;
    assign bus.retire      = retire_s;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault       = fault_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.retire_cnt  = retire_cnt_q;

endmodule
